// File: rtl/ramp_pkg.sv
// Shared types and helpers for the ramp sequencer slice.
package ramp_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD      = 3'd2,
        RAMP_DOWN = 3'd3,
        DONE      = 3'd4
    } ramp_state_t;

    // Prescaler register width; a DIV of 1 still needs a one-bit register.
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/updown_sat_counter.sv
// N-bit up/down counter that sticks at 0 and at all-ones instead of wrapping.
module updown_sat_counter #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         en,
    input  logic         up,
    output logic [N-1:0] Y
);

    localparam logic [N-1:0] Y_MAX = '1;

    // Count one step per enabled cycle, holding at either rail.
    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            Y <= '0;
        end else if (en) begin
            if (up) begin
                if (Y != Y_MAX) Y <= Y + 1'b1;
            end else begin
                if (Y != '0) Y <= Y - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ramp_sequencer.sv
// Trapezoidal ramp controller: rise to target, hold, fall to zero, flag done.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | waiting for start; Y is 0
//   RAMP_UP   | Y steps up once per prescaler tick until it equals target
//   HOLD      | Y parked at peak for hold_cycles+1 clocks
//   RAMP_DOWN | Y steps down once per prescaler tick until it reaches 0
//   DONE      | one-cycle completion pulse, then back to IDLE
module ramp_sequencer
    import ramp_pkg::*;
#(
    parameter int N      = 8,
    parameter int HOLD_W = 8,
    parameter int DIV    = 1
) (
    input  logic              CLK,
    input  logic              N_RESET,
    input  logic              start,
    input  logic [N-1:0]      target,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              abort,
    output logic [N-1:0]      Y,
    output logic              dir,
    output logic              busy,
    output logic              at_peak,
    output logic              done
);

    localparam int              PW         = presc_width(DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);

    ramp_state_t        state_q;
    ramp_state_t        state_d;
    logic [PW-1:0]      presc_q;
    logic               tick;
    logic [N-1:0]       target_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               cnt_en;
    logic               cnt_up;

    assign tick = (presc_q == PRESC_LAST);

    updown_sat_counter #(.N(N)) u_counter (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .en      (cnt_en),
        .up      (cnt_up),
        .Y       (Y)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!N_RESET) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode; abort beats the normal exit from RAMP_UP and HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (abort)                        state_d = RAMP_DOWN;
                else if (tick && (Y == target_q)) state_d = HOLD;
            end
            HOLD: begin
                if (abort || (hold_cnt == '0)) state_d = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (tick && (Y == '0)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state only; counter strobes also fold in tick/abort.
    always_comb begin
        dir     = 1'b0;
        busy    = 1'b0;
        at_peak = 1'b0;
        done    = 1'b0;
        cnt_en  = 1'b0;
        cnt_up  = 1'b0;
        case (state_q)
            RAMP_UP: begin
                dir    = 1'b1;
                busy   = 1'b1;
                cnt_up = 1'b1;
                cnt_en = tick && !abort && (Y != target_q);
            end
            HOLD: begin
                busy    = 1'b1;
                at_peak = 1'b1;
            end
            RAMP_DOWN: begin
                busy   = 1'b1;
                cnt_en = tick && (Y != '0);
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Step prescaler: restarts on any state change so each phase gets full steps.
    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            presc_q <= '0;
        end else if (state_d != state_q) begin
            presc_q <= '0;
        end else if (((state_q == RAMP_UP) || (state_q == RAMP_DOWN)) && !tick) begin
            presc_q <= presc_q + 1'b1;
        end else begin
            presc_q <= '0;
        end
    end

    // Capture the profile shape when a start is accepted so later input changes are ignored.
    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            target_q <= '0;
            hold_q   <= '0;
        end else if ((state_q == IDLE) && start) begin
            target_q <= target;
            hold_q   <= hold_cycles;
        end
    end

    // Hold timer: loaded on entry to HOLD, counts down to zero.
    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            hold_cnt <= '0;
        end else if ((state_q == RAMP_UP) && (state_d == HOLD)) begin
            hold_cnt <= hold_q;
        end else if ((state_q == HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

endmodule

// File: doc/ramp_sequencer.md
# ramp_sequencer

Controller that drives an N-bit saturating up/down counter through a start-triggered trapezoidal profile: ramp up to a programmed target, hold for a programmed number of cycles, ramp back down to zero, then report completion. The block owns the counter's enable and direction and adds a step prescaler and an abort path. It sits between a host/control register bank (start, target, hold, abort) and any consumer of the ramp value (PWM duty, DAC code, LED bar).

## Interface
- N, default 8: counter/target width; Y range 0 to 2^N-1.
- HOLD_W, default 8: width of hold_cycles.
- DIV, default 1: clock cycles per ramp step; legal range is 1 or greater.

- CLK  in  1  clock; all state changes on the rising edge.
- N_RESET  in  1  reset, synchronous, active-low.
- start  in  1  request a profile; sampled only in IDLE.
- target  in  N  peak value; latched when start is accepted.
- hold_cycles  in  HOLD_W  hold length; latched when start is accepted.
- abort  in  1  end the rise/hold early and ramp down immediately.
- Y  out  N  current ramp value (counter register).
- dir  out  1  1 while in RAMP_UP, else 0.
- busy  out  1  1 in RAMP_UP, HOLD and RAMP_DOWN.
- at_peak  out  1  1 in HOLD.
- done  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE, RAMP_UP, HOLD, RAMP_DOWN, DONE.
- Reset (N_RESET=0 at an edge, any state): state goes to IDLE. Y, target_q, hold_q, hold_cnt and the prescaler all go to 0. All outputs read 0 after that edge. Reset overrides start and abort.
- IDLE: if start=1, latch target to target_q and hold_cycles to hold_q, clear the prescaler, and go to RAMP_UP. Y stays at 0.
- tick: 1 when prescaler == DIV-1.
  - The prescaler counts 0 to DIV-1 and wraps.
  - It clears on every state change.
  - With DIV=1, tick is always 1.
- RAMP_UP, on tick: if Y == target_q, go to HOLD and load hold_cnt with hold_q. Otherwise Y = Y+1.
- HOLD, every cycle (not tick-gated): if hold_cnt == 0, go to RAMP_DOWN. Otherwise hold_cnt = hold_cnt-1. hold_cycles=H gives H+1 cycles in HOLD.
- RAMP_DOWN, on tick: if Y == 0, go to DONE. Otherwise Y = Y-1.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally. start is ignored in DONE.
- abort:
  - In RAMP_UP or HOLD, abort=1 at an edge goes to RAMP_DOWN, clears the prescaler and leaves Y unchanged. Abort has priority over the normal transition and the increment in that cycle.
  - Ignored in IDLE, RAMP_DOWN and DONE.
- Arithmetic: Y never wraps. The counter saturates at 0 and 2^N-1. target = 2^N-1 is legal.
- target = 0 is legal: one tick in RAMP_UP with Y=0, then HOLD.
- start held high continuously: a new profile begins on the first IDLE cycle after DONE.

## Timing
- Latency from start accepted at edge e0 to done high is (target+1)*DIV + (hold_cycles+1) + (target+1)*DIV cycles. done is high between that edge and the next one.
- Y first changes at edge e0+DIV.
- busy rises at e0 and falls at the edge that enters DONE.
- Example with DIV=1, target=3, hold=2, start at e0:
  - Y = 1, 2, 3 at e1, e2, e3.
  - HOLD from e4 to e7.
  - Y = 2, 1, 0 at e8, e9, e10.
  - DONE at e11, IDLE at e12.
- All outputs are registered or decoded directly from state. There is no combinational path from any input to any output.

## Structure
- Package ramp_pkg holds:
  - the typedef enum logic [2:0] ramp_state_t for IDLE, RAMP_UP, HOLD, RAMP_DOWN, DONE;
  - the state encodings;
  - a function for the prescaler width, $clog2 of DIV with a minimum of 1.
- Sub-module updown_sat_counter #(N): ports CLK, N_RESET, en, up, Y. It counts on en, with direction set by up, and saturates at 0 and 2^N-1.
- ramp_sequencer holds the FSM, prescaler, hold counter and the input latches.

## Test plan
- Reset mid-ramp: reset during RAMP_UP with Y=5 gives Y=0, state IDLE, and busy/dir/at_peak/done all 0 at the next edge.
- Nominal, DIV=1, target=3, hold=2: Y sequence and state edges match the Timing example exactly, and done pulses for exactly 1 cycle at e11.
- Prescaled, DIV=4, target=2, hold=0:
  - Y steps every 4 cycles.
  - done arrives 3*4 + 1 + 3*4 = 25 cycles after start.
- Boundaries:
  - target=0 gives busy for 1+(H+1)+1 cycles with Y stuck at 0.
  - target=255 with N=8 reaches 255 without wrapping and returns to 0.
- Abort:
  - Abort in RAMP_UP at Y=4, target=10: the next edge enters RAMP_DOWN with Y=4, then Y counts down to 0 and done pulses.
  - Abort in RAMP_DOWN or IDLE has no effect.
- Input latching:
  - Changing target or hold_cycles while busy has no effect on the running profile.
  - start during DONE is ignored.
  - start held high starts a new profile one cycle after DONE.
